// File: rtl/fft_reorder.sv
// Bit-reversed to natural-order reorder buffer for FFT output frames, ping-pong banked.
// Optional macro FFT_REORDER_MAG_EN adds a registered |re|+|im| output (do_mag).
module fft_reorder #(
  parameter int unsigned N     = 256,
  parameter int unsigned WIDTH = 16,
  localparam int unsigned NN   = $clog2(N)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             di_en,
  input  logic [WIDTH-1:0] di_re,
  input  logic [WIDTH-1:0] di_im,
  input  logic             do_ready,
  output logic             do_en,
  output logic [WIDTH-1:0] do_re,
  output logic [WIDTH-1:0] do_im,
  output logic [NN-1:0]    do_idx,
  output logic             do_last,
  output logic             ovf
`ifdef FFT_REORDER_MAG_EN
  ,
  output logic [WIDTH:0]   do_mag
`endif
);

  localparam logic [NN-1:0] LastIdx = NN'(N - 1);

  typedef enum logic [1:0] {BankEmpty, BankFilling, BankFull, BankReading} bank_e;
  typedef enum logic [1:0] {WrIdle, WrWrite, WrDrop} wr_state_e;
  typedef enum logic {RdIdle, RdRead} rd_state_e;

  function automatic logic [NN-1:0] bitrev(input logic [NN-1:0] x);
    logic [NN-1:0] r;
    for (int i = 0; i < NN; i++) r[NN-1-i] = x[i];
    return r;
  endfunction

  bank_e            bank_q [2];
  bank_e            bank_d [2];
  wr_state_e        wr_state_q, wr_state_d;
  rd_state_e        rd_state_q, rd_state_d;
  logic [NN-1:0]    wcnt_q, wcnt_d;
  logic [NN-1:0]    rptr_q, rptr_d;
  logic             wsel_q, wsel_d;
  logic             isel_q, isel_d;
  logic             rsel_q, rsel_d;
  logic             ovf_q, ovf_d;
  logic             v1_q;
  logic [NN-1:0]    idx1_q;

  logic [2*WIDTH-1:0] mem [2*N];
  logic [2*WIDTH-1:0] rd_data;
  logic [WIDTH-1:0]   rd_re, rd_im;

  logic             we, ren, pop, xfer_last;
  logic [NN-1:0]    waddr;

  assign rd_re     = rd_data[2*WIDTH-1:WIDTH];
  assign rd_im     = rd_data[WIDTH-1:0];
  assign pop       = !do_en || do_ready;
  assign xfer_last = do_en && do_ready && (do_idx == LastIdx);
  assign do_last   = do_en && (do_idx == LastIdx);
  assign ovf       = ovf_q;

  always_comb begin
    bank_d[0]  = bank_q[0];
    bank_d[1]  = bank_q[1];
    wr_state_d = wr_state_q;
    rd_state_d = rd_state_q;
    wcnt_d     = wcnt_q;
    rptr_d     = rptr_q;
    wsel_d     = wsel_q;
    isel_d     = isel_q;
    rsel_d     = rsel_q;
    ovf_d      = ovf_q;
    we         = 1'b0;
    ren        = 1'b0;
    waddr      = bitrev(wcnt_q);

    // Release first so a bank freed this edge is seen EMPTY by the writer below.
    if (xfer_last) begin
      bank_d[rsel_q] = BankEmpty;
      rsel_d         = ~rsel_q;
    end

    // Issue side runs one frame ahead of release so consecutive frames stream gap-free.
    unique case (rd_state_q)
      RdIdle: begin
        if (bank_q[isel_q] == BankFull && (!v1_q || pop)) begin
          ren            = 1'b1;
          bank_d[isel_q] = BankReading;
          rptr_d         = rptr_q + 1'b1;
          rd_state_d     = RdRead;
        end
      end
      RdRead: begin
        if (!v1_q || pop) begin
          ren = 1'b1;
          if (rptr_q == LastIdx) begin
            rptr_d     = '0;
            isel_d     = ~isel_q;
            rd_state_d = RdIdle;
          end else begin
            rptr_d = rptr_q + 1'b1;
          end
        end
      end
      default: rd_state_d = RdIdle;
    endcase

    unique case (wr_state_q)
      WrIdle: begin
        if (di_en) begin
          wcnt_d = wcnt_q + 1'b1;
          if (bank_d[wsel_q] == BankEmpty) begin
            we             = 1'b1;
            bank_d[wsel_q] = BankFilling;
            wr_state_d     = WrWrite;
          end else begin
            ovf_d      = 1'b1;
            wr_state_d = WrDrop;
          end
        end
      end
      WrWrite: begin
        if (di_en) begin
          we     = 1'b1;
          wcnt_d = wcnt_q + 1'b1;
          if (wcnt_q == LastIdx) begin
            bank_d[wsel_q] = BankFull;
            wsel_d         = ~wsel_q;
            wr_state_d     = WrIdle;
          end
        end
      end
      WrDrop: begin
        if (di_en) begin
          wcnt_d = wcnt_q + 1'b1;
          if (wcnt_q == LastIdx) wr_state_d = WrIdle;
        end
      end
      default: wr_state_d = WrIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bank_q[0]  <= BankEmpty;
      bank_q[1]  <= BankEmpty;
      wr_state_q <= WrIdle;
      rd_state_q <= RdIdle;
      wcnt_q     <= '0;
      rptr_q     <= '0;
      wsel_q     <= 1'b0;
      isel_q     <= 1'b0;
      rsel_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      bank_q[0]  <= bank_d[0];
      bank_q[1]  <= bank_d[1];
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      wcnt_q     <= wcnt_d;
      rptr_q     <= rptr_d;
      wsel_q     <= wsel_d;
      isel_q     <= isel_d;
      rsel_q     <= rsel_d;
      ovf_q      <= ovf_d;
    end
  end

  // Sample RAM: no reset, contents are don't-care until written.
  always_ff @(posedge clock) begin
    if (we) mem[{wsel_q, waddr}] <= {di_re, di_im};
    if (ren) rd_data <= mem[{isel_q, rptr_q}];
  end

`ifdef FFT_REORDER_MAG_EN
  function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + 1'b1) : x;
  endfunction

  logic [WIDTH:0] mag_next;
  assign mag_next = {1'b0, abs_w(rd_re)} + {1'b0, abs_w(rd_im)};
`endif

  // Stage 1 is the RAM output register; stage 2 is the output register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      v1_q   <= 1'b0;
      idx1_q <= '0;
      do_en  <= 1'b0;
      do_re  <= '0;
      do_im  <= '0;
      do_idx <= '0;
`ifdef FFT_REORDER_MAG_EN
      do_mag <= '0;
`endif
    end else begin
      if (ren) begin
        v1_q   <= 1'b1;
        idx1_q <= rptr_q;
      end else if (pop) begin
        v1_q <= 1'b0;
      end
      if (pop) begin
        do_en <= v1_q;
        if (v1_q) begin
          do_re  <= rd_re;
          do_im  <= rd_im;
          do_idx <= idx1_q;
`ifdef FFT_REORDER_MAG_EN
          do_mag <= mag_next;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_reorder.sv
// Directed bench for fft_reorder: an N=8 instance for ordering, stall, overflow and reset
// scenarios, and an N=256 instance for back-to-back streaming.
module tb_fft_reorder;

  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset;

  logic        a_en, a_ready, a_oen, a_last, a_ovf;
  logic [15:0] a_re, a_im, a_ore, a_oim;
  logic [2:0]  a_idx;
  logic        b_en, b_ready, b_oen, b_last, b_ovf;
  logic [15:0] b_re, b_im, b_ore, b_oim;
  logic [7:0]  b_idx;
`ifdef FFT_REORDER_MAG_EN
  logic [16:0] a_mag, b_mag;
`endif

  int checks = 0;
  int errors = 0;
  int exp8 [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  fft_reorder #(.N(8), .WIDTH(16)) dut8 (
    .clock(clock), .reset(reset), .di_en(a_en), .di_re(a_re), .di_im(a_im),
    .do_ready(a_ready), .do_en(a_oen), .do_re(a_ore), .do_im(a_oim), .do_idx(a_idx),
    .do_last(a_last), .ovf(a_ovf)
`ifdef FFT_REORDER_MAG_EN
    , .do_mag(a_mag)
`endif
  );

  fft_reorder #(.N(256), .WIDTH(16)) dut256 (
    .clock(clock), .reset(reset), .di_en(b_en), .di_re(b_re), .di_im(b_im),
    .do_ready(b_ready), .do_en(b_oen), .do_re(b_ore), .do_im(b_oim), .do_idx(b_idx),
    .do_last(b_last), .ovf(b_ovf)
`ifdef FFT_REORDER_MAG_EN
    , .do_mag(b_mag)
`endif
  );

  function automatic int brev(input int x, input int bits);
    int r = 0;
    for (int i = 0; i < bits; i++) if (x[i]) r |= (1 << (bits - 1 - i));
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drives one 8-sample frame (re = tag+n, im = ~re); returns #1 after the edge taking sample 7.
  task automatic send8(input logic [15:0] tag);
    for (int n = 0; n < 8; n++) begin
      tick();
      a_en = 1'b1;
      a_re = tag + 16'(n);
      a_im = ~(tag + 16'(n));
    end
    tick();
    a_en = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({a_oen, a_last, a_ovf} !== 3'b000 || a_idx !== 3'd0 || a_ore !== 16'd0 || a_oim !== 16'd0) begin
      errors++;
      $display("FAIL reset_n8: en/last/ovf=%b idx=%0d re=%h im=%h required all zero",
               {a_oen, a_last, a_ovf}, a_idx, a_ore, a_oim);
    end
    checks++;
    if ({b_oen, b_last, b_ovf} !== 3'b000 || b_idx !== 8'd0 || b_ore !== 16'd0 || b_oim !== 16'd0) begin
      errors++;
      $display("FAIL reset_n256: en/last/ovf=%b idx=%0d re=%h im=%h required all zero",
               {b_oen, b_last, b_ovf}, b_idx, b_ore, b_oim);
    end
`ifdef FFT_REORDER_MAG_EN
    checks++;
    if (a_mag !== 17'd0) begin
      errors++;
      $display("FAIL reset_mag: got %h required 0", a_mag);
    end
`endif
  endtask

  task automatic test_order();
    a_ready = 1'b1;
    send8(16'h0000);
    checks++;
    if (a_oen !== 1'b0) begin
      errors++;
      $display("FAIL order_early_T: do_en=%b required 0", a_oen);
    end
    tick();
    checks++;
    if (a_oen !== 1'b0) begin
      errors++;
      $display("FAIL order_early_T1: do_en=%b required 0", a_oen);
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if (a_oen !== 1'b1 || a_idx !== 3'(k) || a_last !== (k == 7) ||
          a_ore !== 16'(exp8[k]) || a_oim !== ~16'(exp8[k])) begin
        errors++;
        $display("FAIL order_k%0d: en=%b idx=%0d last=%b re=%0d im=%h required en=1 idx=%0d last=%b re=%0d",
                 k, a_oen, a_idx, a_last, a_ore, a_oim, k, k == 7, exp8[k]);
      end
    end
    tick();
    checks++;
    if (a_oen !== 1'b0) begin
      errors++;
      $display("FAIL order_after: do_en=%b required 0", a_oen);
    end
  endtask

  task automatic test_back_to_back();
    b_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 512; i++) begin
          tick();
          b_en = 1'b1;
          b_re = 16'(i);
          b_im = 16'(i) ^ 16'h5a5a;
        end
        tick();
        b_en = 1'b0;
      end
      begin
        int w = 0;
        while (!b_oen && w < 700) begin
          tick();
          w++;
        end
        checks++;
        if (!b_oen) begin
          errors++;
          $display("FAIL b2b_start: do_en=%b after %0d cycles required 1", b_oen, w);
        end
        for (int j = 0; j < 512; j++) begin
          int k = j % 256;
          int e = (j / 256) * 256 + brev(k, 8);
          checks++;
          if (b_oen !== 1'b1 || b_idx !== 8'(k) || b_last !== (k == 255) ||
              b_ore !== 16'(e) || b_oim !== (16'(e) ^ 16'h5a5a)) begin
            errors++;
            $display("FAIL b2b_j%0d: en=%b idx=%0d last=%b re=%0d required en=1 idx=%0d last=%b re=%0d",
                     j, b_oen, b_idx, b_last, b_ore, k, k == 255, e);
          end
          tick();
        end
      end
    join
    checks++;
    if (b_oen !== 1'b0 || b_ovf !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: en=%b ovf=%b required 0 0", b_oen, b_ovf);
    end
  endtask

  task automatic test_stall();
    logic [3:0]  pat = 4'b1001;
    int          k = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_re = '0;
    logic [2:0]  prev_idx = '0;
    a_ready = 1'b1;
    send8(16'h0100);
    for (int c = 0; c < 60 && k < 8; c++) begin
      tick();
      if (prev_stall) begin
        checks++;
        if (a_oen !== 1'b1 || a_ore !== prev_re || a_idx !== prev_idx) begin
          errors++;
          $display("FAIL stall_hold_c%0d: en=%b re=%h idx=%0d required 1 %h %0d",
                   c, a_oen, a_ore, a_idx, prev_re, prev_idx);
        end
      end
      if (a_oen) begin
        checks++;
        if (a_idx !== 3'(k) || a_ore !== 16'h0100 + 16'(exp8[k])) begin
          errors++;
          $display("FAIL stall_data_k%0d: idx=%0d re=%h required idx=%0d re=%h",
                   k, a_idx, a_ore, k, 16'h0100 + 16'(exp8[k]));
        end
      end
      a_ready = pat[c % 4];
      prev_stall = a_oen && !a_ready;
      prev_re = a_ore;
      prev_idx = a_idx;
      if (a_oen && a_ready) k++;
    end
    checks++;
    if (k != 8) begin
      errors++;
      $display("FAIL stall_count: transfers=%0d required 8", k);
    end
    a_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (a_oen !== 1'b0) begin
      errors++;
      $display("FAIL stall_extra: do_en=%b required 0", a_oen);
    end
  endtask

  task automatic test_overflow();
    int cnt = 0;
    a_ready = 1'b0;
    send8(16'h1000);
    send8(16'h2000);
    send8(16'h3000);
    tick();
    checks++;
    if (a_ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_flag: ovf=%b required 1", a_ovf);
    end
    a_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (a_oen) begin
        if (cnt < 16) begin
          logic [15:0] e = (cnt < 8 ? 16'h1000 : 16'h2000) + 16'(exp8[cnt % 8]);
          checks++;
          if (a_ore !== e || a_idx !== 3'(cnt % 8)) begin
            errors++;
            $display("FAIL ovf_data_%0d: re=%h idx=%0d required re=%h idx=%0d",
                     cnt, a_ore, a_idx, e, cnt % 8);
          end
        end
        cnt++;
      end
      tick();
    end
    checks++;
    if (cnt != 16 || a_ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_count: transfers=%0d ovf=%b required 16 1", cnt, a_ovf);
    end
  endtask

  task automatic test_midreset();
    int cnt = 0;
    a_ready = 1'b0;
    send8(16'h4000);
    tick();
    tick();
    checks++;
    if (a_oen !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre: do_en=%b required 1", a_oen);
    end
    for (int n = 0; n < 4; n++) begin
      tick();
      a_en = 1'b1;
      a_re = 16'h6000 + 16'(n);
      a_im = 16'h0;
    end
    reset = 1'b0;
    #1;
    checks++;
    if (a_oen !== 1'b0 || a_ovf !== 1'b0 || a_idx !== 3'd0 || a_ore !== 16'd0) begin
      errors++;
      $display("FAIL midrst_async: en=%b ovf=%b idx=%0d re=%h required 0 0 0 0",
               a_oen, a_ovf, a_idx, a_ore);
    end
    a_en = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    a_ready = 1'b1;
    send8(16'h5000);
    for (int c = 0; c < 30; c++) begin
      if (a_oen) begin
        checks++;
        if (cnt >= 8 || a_ore !== 16'h5000 + 16'(exp8[cnt % 8]) || a_idx !== 3'(cnt % 8)) begin
          errors++;
          $display("FAIL midrst_data_%0d: re=%h idx=%0d required re=%h idx=%0d",
                   cnt, a_ore, a_idx, 16'h5000 + 16'(exp8[cnt % 8]), cnt % 8);
        end
        cnt++;
      end
      tick();
    end
    checks++;
    if (cnt != 8) begin
      errors++;
      $display("FAIL midrst_count: transfers=%0d required 8", cnt);
    end
  endtask

`ifdef FFT_REORDER_MAG_EN
  task automatic test_mag();
    a_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      tick();
      a_en = 1'b1;
      a_re = (n == 0) ? 16'h8000 : (n == 5) ? 16'hfffd : 16'h0000;
      a_im = (n == 5) ? 16'h0004 : 16'h0000;
    end
    tick();
    a_en = 1'b0;
    tick();
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k == 0 || k == 5) begin
        checks++;
        if (a_oen !== 1'b1 || a_idx !== 3'(k) ||
            a_mag !== ((k == 0) ? 17'h08000 : 17'd7)) begin
          errors++;
          $display("FAIL mag_idx%0d: en=%b idx=%0d mag=%h required 1 %0d %h",
                   k, a_oen, a_idx, a_mag, k, (k == 0) ? 17'h08000 : 17'd7);
        end
      end
    end
    tick();
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    a_en = 1'b0; a_re = '0; a_im = '0; a_ready = 1'b0;
    b_en = 1'b0; b_re = '0; b_im = '0; b_ready = 1'b0;
    #12;
    test_reset();
    tick();
    reset = 1'b1;
    tick();
    test_order();
    test_back_to_back();
    test_stall();
    test_overflow();
    test_midreset();
`ifdef FFT_REORDER_MAG_EN
    test_mag();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
